// File: rtl/apb_mig_pkg.sv
// Shared APB types for the MIG-side control fabric.
// Holds the demux FSM state encoding and the common address/data/strobe widths.
package apb_mig_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef logic [APB_ADDR_W-1:0]   apb_addr_t;
  typedef logic [APB_DATA_W-1:0]   data_t;
  typedef logic [APB_DATA_W/8-1:0] apb_strb_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_demux_state_e;

  // A single-channel fabric still needs a 1-bit index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_addr_decoder.sv
// Base/mask address decoder.
// Purely combinational; the lowest matching channel wins.
module apb_addr_decoder
  import apb_mig_pkg::*;
#(
  parameter int ADDR_W = $bits(apb_addr_t),
  parameter int N_SLV  = 4,
  parameter int IDX_W  = idx_width(N_SLV),
  parameter logic [N_SLV-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);
  // Scan from the top so the lowest hitting index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((addr_i & SLV_MASK[k]) == SLV_BASE[k]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/apb_demux.sv
// APB 1-to-N demultiplexer with registered decode and access-phase watchdog.
// Every output is a flop; misses and hung slaves are answered locally with an error.
module apb_demux
  import apb_mig_pkg::*;
#(
  parameter int ADDR_W  = $bits(apb_addr_t),
  parameter int DATA_W  = $bits(data_t),
  parameter int N_SLV   = 4,
  parameter logic [N_SLV-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV-1:0][ADDR_W-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 256
) (
  input  logic                            pclk_i,
  input  logic                            preset_ni,
  input  logic [ADDR_W-1:0]               paddr_i,
  input  logic [DATA_W-1:0]               pwdata_i,
  input  logic                            pwrite_i,
  input  logic                            psel_i,
  input  logic                            penable_i,
  input  logic [DATA_W/8-1:0]             pstrb_i,
  output logic [DATA_W-1:0]               prdata_o,
  output logic                            pready_o,
  output logic                            pslverr_o,
  output logic [ADDR_W-1:0]               m_paddr_o,
  output logic [DATA_W-1:0]               m_pwdata_o,
  output logic                            m_pwrite_o,
  output logic [DATA_W/8-1:0]             m_pstrb_o,
  output logic [N_SLV-1:0]                m_psel_o,
  output logic                            m_penable_o,
  input  logic [N_SLV-1:0][DATA_W-1:0]    m_prdata_i,
  input  logic [N_SLV-1:0]                m_pready_i,
  input  logic [N_SLV-1:0]                m_pslverr_i
);
  localparam int IDX_W  = idx_width(N_SLV);
  localparam int STRB_W = DATA_W / 8;

  apb_demux_state_e    state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [N_SLV-1:0]    sel_q, sel_d;
  logic                pen_q, pen_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                dec_hit, tmo;
  logic [IDX_W-1:0]    dec_idx;

  apb_addr_decoder #(
    .ADDR_W(ADDR_W), .N_SLV(N_SLV), .IDX_W(IDX_W),
    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_dec (
    .addr_i(paddr_i),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  // Counter runs only in ACCESS and restarts from zero on every other state.
  if (TIMEOUT > 0) begin : g_wdog
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge pclk_i) begin
      if (!preset_ni) cnt_q <= '0;
      else            cnt_q <= cnt_d;
    end
    assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
  end else begin : g_no_wdog
    assign tmo = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    strb_d  = strb_q;
    sel_d   = '0;
    pen_d   = 1'b0;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          addr_d  = paddr_i;
          wdata_d = pwdata_i;
          write_d = pwrite_i;
          strb_d  = pstrb_i;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d = SETUP;
            sel_d   = N_SLV'(1) << dec_idx;
          end else begin
            state_d = RESP;
            rdy_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        sel_d   = N_SLV'(1) << idx_q;
        pen_d   = 1'b1;
      end
      ACCESS: begin
        if (m_pready_i[idx_q]) begin
          state_d = RESP;
          rdy_d   = 1'b1;
          err_d   = m_pslverr_i[idx_q];
          rdata_d = write_q ? '0 : m_prdata_i[idx_q];
        end else if (tmo) begin
          state_d = RESP;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          sel_d   = N_SLV'(1) << idx_q;
          pen_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      sel_q   <= '0;
      pen_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      strb_q  <= strb_d;
      sel_q   <= sel_d;
      pen_q   <= pen_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign m_paddr_o   = addr_q;
  assign m_pwdata_o  = wdata_q;
  assign m_pwrite_o  = write_q;
  assign m_pstrb_o   = strb_q;
  assign m_psel_o    = sel_q;
  assign m_penable_o = pen_q;
  assign pready_o    = rdy_q;
  assign pslverr_o   = err_q;
  assign prdata_o    = rdata_q;
endmodule

// File: tb/tb_apb_demux.sv
// Directed bench for apb_demux: four channels, TIMEOUT=8, behavioural wait-state slaves.
// Latency is counted in upstream clock edges from the SETUP sample (T0) to pready_o sample.
module tb_apb_demux;
  localparam int N = 4;
  localparam logic [N-1:0][31:0] BASE = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_1100};
  localparam logic [N-1:0][31:0] MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00};

  logic pclk = 1'b0, preset_ni;
  logic [31:0] paddr, pwdata, prdata_o, m_paddr_o, m_pwdata_o;
  logic pwrite, psel, penable, pready_o, pslverr_o, m_pwrite_o, m_penable_o;
  logic [3:0] pstrb, m_pstrb_o;
  logic [N-1:0] m_psel_o, m_pready_i, m_pslverr_i;
  logic [N-1:0][31:0] m_prdata_i;

  int wait_cfg [N];
  logic [31:0] rdata_cfg [N];
  logic err_cfg [N];
  int wcnt;

  int checks = 0, passed = 0;
  int r_lat;
  logic [31:0] r_rdata, acc_addr, acc_wdata;
  logic [3:0] acc_strb;
  logic r_err, acc_write, resp_busy;
  logic [N-1:0] sel_acc;

  always #5 pclk = ~pclk;

  apb_demux #(
    .ADDR_W(32), .DATA_W(32), .N_SLV(N), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8)
  ) dut (
    .pclk_i(pclk), .preset_ni(preset_ni),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite), .psel_i(psel),
    .penable_i(penable), .pstrb_i(pstrb),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pwrite_o(m_pwrite_o),
    .m_pstrb_o(m_pstrb_o), .m_psel_o(m_psel_o), .m_penable_o(m_penable_o),
    .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i)
  );

  // Slave k readies after wait_cfg[k] access cycles; negative means never.
  always @(posedge pclk) begin
    if (m_penable_o && (|m_psel_o) && !(|m_pready_i)) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    m_pready_i  = '0;
    m_pslverr_i = '0;
    m_prdata_i  = '0;
    for (int k = 0; k < N; k++) begin
      m_prdata_i[k]  = rdata_cfg[k];
      m_pready_i[k]  = m_psel_o[k] && m_penable_o && (wait_cfg[k] >= 0) && (wcnt == wait_cfg[k]);
      m_pslverr_i[k] = m_pready_i[k] && err_cfg[k];
    end
  end

  task automatic set_slv(input int k, input int w, input logic [31:0] d, input logic e);
    wait_cfg[k] = w; rdata_cfg[k] = d; err_cfg[k] = e;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    @(posedge pclk); #1;
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    sel_acc = '0; acc_addr = '0; acc_wdata = '0; acc_strb = '0; acc_write = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    r_lat = 0;
    while (!pready_o) begin
      sel_acc |= m_psel_o;
      if (m_penable_o) begin
        acc_addr = m_paddr_o; acc_wdata = m_pwdata_o; acc_strb = m_pstrb_o; acc_write = m_pwrite_o;
      end
      if (r_lat == 40) break;
      @(posedge pclk); #1;
      r_lat++;
    end
    r_lat++;
    r_rdata = prdata_o; r_err = pslverr_o;
    resp_busy = (|m_psel_o) | m_penable_o;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (pready_o !== 1'b0 || pslverr_o !== 1'b0 || prdata_o !== 32'h0)
      $display("FAIL reset_up: rdy=%b err=%b rdata=%h want 0", pready_o, pslverr_o, prdata_o); else passed++;
    checks++; if (m_psel_o !== 4'h0 || m_penable_o !== 1'b0)
      $display("FAIL reset_sel: psel=%b pen=%b want 0", m_psel_o, m_penable_o); else passed++;
    checks++; if (m_paddr_o !== 32'h0 || m_pwdata_o !== 32'h0 || m_pstrb_o !== 4'h0 || m_pwrite_o !== 1'b0)
      $display("FAIL reset_req: addr=%h wdata=%h strb=%h wr=%b want 0", m_paddr_o, m_pwdata_o, m_pstrb_o, m_pwrite_o); else passed++;
  endtask

  task automatic test_zero_wait_read();
    set_slv(2, 0, 32'hDEAD_BEEF, 1'b0);
    xfer(32'h2004, 1'b0, 32'h0, 4'h0);
    checks++; if (r_lat !== 3) $display("FAIL zw_lat: got %0d want 3", r_lat); else passed++;
    checks++; if (r_rdata !== 32'hDEAD_BEEF || r_err !== 1'b0)
      $display("FAIL zw_resp: rdata=%h err=%b want deadbeef 0", r_rdata, r_err); else passed++;
    checks++; if (sel_acc !== 4'b0100) $display("FAIL zw_sel: got %b want 0100", sel_acc); else passed++;
    checks++; if (acc_addr !== 32'h2004) $display("FAIL zw_addr: got %h want 00002004", acc_addr); else passed++;
  endtask

  task automatic test_wait_write();
    set_slv(1, 3, 32'hAAAA_5555, 1'b0);
    xfer(32'h1010, 1'b1, 32'h1234_5678, 4'b0101);
    checks++; if (r_lat !== 6) $display("FAIL ww_lat: got %0d want 6", r_lat); else passed++;
    checks++; if (r_rdata !== 32'h0 || r_err !== 1'b0)
      $display("FAIL ww_resp: rdata=%h err=%b want 0 0", r_rdata, r_err); else passed++;
    checks++; if (acc_wdata !== 32'h1234_5678 || acc_strb !== 4'b0101 || acc_write !== 1'b1)
      $display("FAIL ww_req: wdata=%h strb=%b wr=%b want 12345678 0101 1", acc_wdata, acc_strb, acc_write); else passed++;
    checks++; if (sel_acc !== 4'b0010) $display("FAIL ww_sel: got %b want 0010", sel_acc); else passed++;
  endtask

  task automatic test_unmapped();
    xfer(32'hF000, 1'b0, 32'h0, 4'h0);
    checks++; if (r_lat !== 1) $display("FAIL um_lat: got %0d want 1", r_lat); else passed++;
    checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0)
      $display("FAIL um_resp: err=%b rdata=%h want 1 0", r_err, r_rdata); else passed++;
    checks++; if (sel_acc !== 4'b0000 || resp_busy !== 1'b0)
      $display("FAIL um_sel: sel=%b busy=%b want 0", sel_acc, resp_busy); else passed++;
  endtask

  task automatic test_timeout();
    set_slv(0, -1, 32'hBAD0_BAD0, 1'b0);
    xfer(32'h1100, 1'b0, 32'h0, 4'h0);
    checks++; if (r_lat !== 10) $display("FAIL to_lat: got %0d want 10", r_lat); else passed++;
    checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0)
      $display("FAIL to_resp: err=%b rdata=%h want 1 0", r_err, r_rdata); else passed++;
    checks++; if (resp_busy !== 1'b0) $display("FAIL to_resp_idle: got %b want 0", resp_busy); else passed++;
    set_slv(1, 0, 32'h1111_2222, 1'b0);
    xfer(32'h1020, 1'b0, 32'h0, 4'h0);
    checks++; if (r_lat !== 3 || r_rdata !== 32'h1111_2222 || r_err !== 1'b0)
      $display("FAIL to_next: lat=%0d rdata=%h err=%b want 3 11112222 0", r_lat, r_rdata, r_err); else passed++;
  endtask

  task automatic test_slave_err();
    set_slv(3, 1, 32'h0000_0055, 1'b1);
    xfer(32'h3008, 1'b0, 32'h0, 4'h0);
    checks++; if (r_lat !== 4 || r_err !== 1'b1)
      $display("FAIL se_resp: lat=%0d err=%b want 4 1", r_lat, r_err); else passed++;
    checks++; if (sel_acc !== 4'b1000) $display("FAIL se_sel: got %b want 1000", sel_acc); else passed++;
  endtask

  task automatic test_overlap();
    set_slv(0, 0, 32'h0C0C_0C0C, 1'b0);
    set_slv(1, 0, 32'h1111_1111, 1'b0);
    xfer(32'h1104, 1'b0, 32'h0, 4'h0);
    checks++; if (sel_acc !== 4'b0001 || r_rdata !== 32'h0C0C_0C0C)
      $display("FAIL ov_sel: sel=%b rdata=%h want 0001 0c0c0c0c", sel_acc, r_rdata); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    set_slv(2, -1, 32'h0, 1'b0);
    @(posedge pclk); #1;
    paddr = 32'h2040; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    while (!m_penable_o && n < 10) begin @(posedge pclk); #1; n++; end
    checks++; if (m_penable_o !== 1'b1) $display("FAIL rm_access: pen=%b want 1", m_penable_o); else passed++;
    preset_ni = 1'b0;
    @(posedge pclk); #1;
    checks++; if (m_psel_o !== 4'h0 || m_penable_o !== 1'b0 || pready_o !== 1'b0 || pslverr_o !== 1'b0)
      $display("FAIL rm_ctrl: psel=%b pen=%b rdy=%b err=%b want 0", m_psel_o, m_penable_o, pready_o, pslverr_o); else passed++;
    checks++; if (m_paddr_o !== 32'h0 || m_pwdata_o !== 32'h0 || m_pwrite_o !== 1'b0 || m_pstrb_o !== 4'h0 || prdata_o !== 32'h0)
      $display("FAIL rm_data: addr=%h wdata=%h wr=%b strb=%h rdata=%h want 0", m_paddr_o, m_pwdata_o, m_pwrite_o, m_pstrb_o, prdata_o); else passed++;
    psel = 1'b0; penable = 1'b0;
    preset_ni = 1'b1;
    @(posedge pclk); #1;
  endtask

  initial begin
    preset_ni = 1'b0;
    paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0; pstrb = '0;
    for (int k = 0; k < N; k++) set_slv(k, 0, 32'h0, 1'b0);
    repeat (3) @(posedge pclk);
    #1;
    test_reset();
    preset_ni = 1'b1;
    test_zero_wait_read();
    test_wait_write();
    test_unmapped();
    test_timeout();
    test_slave_err();
    test_overlap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
